// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sequencing byte producers onto one uart_tx
module uart_tx_arb #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int GAP_TICKS = 0,
   localparam int ID_W     = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      tick_baud,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_start,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_done,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy
);

   localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   logic [1:0]       state_q;
   logic [ID_W-1:0]  last_q;
   logic [GAP_W-1:0] gap_cnt_q;
   logic             win_found;
   logic [ID_W-1:0]  win_idx;

   // Round-robin search: first pending requester after the last winner, wrapping.
   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = (int'(last_q) + off) % NUM_REQ;
         if (!win_found && req_valid[ID_W'(idx)]) begin
            win_found = 1'b1;
            win_idx   = ID_W'(idx);
         end
      end
   end

   // Sequencer: grant, strobe the transmitter, wait for the frame, then the optional idle gap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         last_q    <= ID_W'(NUM_REQ - 1);
         gap_cnt_q <= '0;
         req_ready <= '0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
         grant_id  <= '0;
         busy      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               tx_start <= 1'b0;
               if (win_found) begin
                  req_ready <= NUM_REQ'(1) << win_idx;
                  tx_data   <= req_data[win_idx*DATA_W +: DATA_W];
                  grant_id  <= win_idx;
                  last_q    <= win_idx;
                  busy      <= 1'b1;
                  state_q   <= ST_START;
               end else begin
                  req_ready <= '0;
                  busy      <= 1'b0;
               end
            end
            ST_START: begin
               req_ready <= '0;
               tx_start  <= 1'b1;
               state_q   <= ST_WAIT;
            end
            ST_WAIT: begin
               req_ready <= '0;
               tx_start  <= 1'b0;
               // A tick coinciding with tx_done is dropped: the gap count starts from zero.
               if (tx_done) begin
                  gap_cnt_q <= '0;
                  if (GAP_TICKS > 0) begin
                     state_q <= ST_GAP;
                  end else begin
                     state_q <= ST_IDLE;
                     busy    <= 1'b0;
                  end
               end
            end
            default: begin
               req_ready <= '0;
               tx_start  <= 1'b0;
               if (tick_baud) begin
                  if (gap_cnt_q == GAP_LAST) begin
                     state_q <= ST_IDLE;
                     busy    <= 1'b0;
                  end else begin
                     gap_cnt_q <= gap_cnt_q + 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and sequencer that shares one `uart_tx` transmitter among `NUM_REQ` byte producers. It accepts a byte from one requester at a time through a valid/ready handshake and latches it into a holding register. It then issues a single-cycle start to the transmitter and waits for frame completion. Optionally it enforces an inter-frame idle gap, counted in baud ticks, before granting the next requester. It sits between the command/status sources and the `uart_tx` instance.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2–16.
- `DATA_W`, 8: byte width; must equal the transmitter's `count`.
- `GAP_TICKS`, 0: `tick_baud` pulses of idle line enforced after each frame; legal range 0–255.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous assert, active-low reset.
- `tick_baud` in 1: one-cycle baud strobe shared with the transmitter.
- `req_valid` in `NUM_REQ`: bit i high means requester i has a byte pending.
- `req_data` in `NUM_REQ*DATA_W`: requester i byte at `[i*DATA_W +: DATA_W]`.
- `req_ready` out `NUM_REQ`: one-hot, one-cycle accept pulse.
- `tx_start` out 1: one-cycle start strobe to the transmitter.
- `tx_data` out `DATA_W`: held byte; stable from the accept cycle until the next accept.
- `tx_done` in 1: one-cycle pulse from the transmitter at the end of the stop bit.
- `grant_id` out `max(1,$clog2(NUM_REQ))`: index of the last accepted requester.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, START, WAIT, GAP. All outputs are registered.
- **IDLE**
  - If any `req_valid` is high, choose winner w by round-robin. The search starts at `last+1` mod `NUM_REQ` and increases with wrap-around.
  - On that edge: `req_ready[w]`←1, `tx_data`←slice w, `grant_id`←w, `last`←w, next state START.
  - If no `req_valid` is high, stay in IDLE with `req_ready`=0.
- **START**
  - `req_ready`←0, `tx_start`←1.
  - Next state WAIT. START lasts exactly one cycle.
- **WAIT**
  - `tx_start`←0.
  - On `tx_done`: go to GAP if `GAP_TICKS`>0, otherwise go to IDLE.
- **GAP**
  - Gap counter (width `$clog2(GAP_TICKS+1)`) is cleared on entry and increments on each `tick_baud`.
  - When a tick arrives with counter = `GAP_TICKS-1`, go to IDLE.
- **Handshake:** a transfer occurs only on the edge where `req_ready[i]` is driven high. The requester's `req_valid` and data must be stable from assertion until it sees `req_ready[i]`=1. A requester may withdraw `req_valid` at any time before it is granted; no byte is lost or duplicated.
- **Priority pointer:** `last` resets to `NUM_REQ-1`, so requester 0 has first priority after reset.
- **Stray events:** `tx_done` outside WAIT is ignored. `tick_baud` outside GAP is ignored by the arbiter.
- **Simultaneous events:**
  - `tx_done` and `tick_baud` in the same WAIT cycle: go to GAP; that tick is not counted.
  - `req_valid` changing in the grant cycle: the value sampled on the grant edge decides the winner.

## Timing
- Reset values: `req_ready`=0, `tx_start`=0, `tx_data`=0, `grant_id`=0, `busy`=0, state IDLE, `last`=`NUM_REQ-1`, gap counter 0.
- Reset asserted mid-operation:
  - All of the above take effect immediately (asynchronous).
  - The in-flight byte is abandoned.
  - The transmitter is reset by the same `rst_n`.
- Latency, with `req_valid` sampled high in IDLE at edge k:
  - `req_ready` high in cycle k..k+1.
  - `tx_start` high in cycle k+1..k+2.
  - `busy` rises at edge k.
- Return to IDLE:
  - `GAP_TICKS`=0: the edge after `tx_done` is sampled; a new grant is possible one edge later.
  - `GAP_TICKS`=N: the edge that samples the Nth `tick_baud` after `tx_done`.
- Throughput: at most one grant per frame.
  - Minimum spacing between `tx_start` pulses: frame time + 3 cycles + N baud periods.

## Test plan
- **Reset defaults:** hold `rst_n`=0, then release, with no requests → all outputs 0 and `busy`=0 for 20 cycles; `tx_start` never pulses.
- **Single request:** `req_valid`=4'b0100, byte 0xA5 → `req_ready`=4'b0100 for one cycle, `tx_data`=0xA5, `grant_id`=2, `tx_start` one cycle later; after `tx_done`, `busy` falls.
- **Round-robin:** all four `req_valid` held high, `tx_done` model at 10 cycles → grant order 0,1,2,3,0. `grant_id` sequence matches, and each `req_ready` is a single-cycle pulse.
- **Inter-frame gap:** `GAP_TICKS`=2, `tx_done` coincident with a `tick_baud` → that tick is ignored. IDLE is reached on the second subsequent tick, and no grant occurs before then.
- **Withdraw and stray done:** requester 1 raises then drops `req_valid` while another frame is in WAIT; a stray `tx_done` arrives in IDLE → requester 1 is never granted and the FSM does not move.
- **Reset mid-frame:** assert `rst_n`=0 during WAIT → all outputs return to reset values immediately, and the next grant goes to requester 0.
